// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, message-locked arbiter sharing one uart_tx among
//            NUM_REQ valid/ready word streams, with an idle-line guard time.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int W_DATA     = 16,
    parameter int GAP_CLOCKS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          s_valid,
    input  logic [NUM_REQ*W_DATA-1:0]   s_data,
    input  logic [NUM_REQ-1:0]          s_last,
    output logic [NUM_REQ-1:0]          s_ready,
    output logic                        m_valid,
    output logic [W_DATA-1:0]           m_data,
    input  logic                        m_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy
);

    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W    = (GAP_CLOCKS > 0) ? $clog2(GAP_CLOCKS + 1) : 1;
    localparam int GAP_LAST = (GAP_CLOCKS > 0) ? (GAP_CLOCKS - 1) : 0;
    localparam int REQ_LAST = NUM_REQ - 1;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_LOCK = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;

    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     scan_idx;
    logic [PTR_W-1:0]     owner_next;
    logic                 owner_xfer;

    // First valid requester scanning ptr, ptr+1, ... with wrap at NUM_REQ-1.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && s_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            if (scan_idx == PTR_W'(REQ_LAST)) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + PTR_W'(1);
            end
        end
    end

    always_comb begin
        if (owner_q == PTR_W'(REQ_LAST)) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + PTR_W'(1);
        end
    end

    assign owner_xfer = s_valid[owner_q] && m_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        gap_cnt_d = gap_cnt_q;
        s_ready   = '0;
        m_valid   = 1'b0;
        m_data    = '0;

        case (state_q)
            ST_ARB: begin
                if (found) begin
                    owner_d = winner;
                    grant_d = NUM_REQ'(1) << winner;
                    state_d = ST_LOCK;
                end
            end

            ST_LOCK: begin
                m_valid          = s_valid[owner_q];
                m_data           = s_data[owner_q*W_DATA +: W_DATA];
                s_ready[owner_q] = m_ready;
                if (owner_xfer && s_last[owner_q]) begin
                    ptr_d     = owner_next;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    if (GAP_CLOCKS > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end

            ST_GAP: begin
                // Only idle-line clocks count; time uart_tx spends sending is excluded.
                if (m_ready) begin
                    if (gap_cnt_q == CNT_W'(GAP_LAST)) begin
                        state_d = ST_ARB;
                    end else begin
                        gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_ARB);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Randomized scoreboard bench for uart_tx_arbiter at three guard times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int NCFG = 3;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } word_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   phase;
    bit   rst_ones;
    bit   rdy_force_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d t=%0t: got %0h expected %0h", nm, cfg, $time, act, exp);
        end
    endtask

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int GAP = (c == 0) ? 2 : ((c == 1) ? 0 : 4);

        logic [N-1:0]   s_valid;
        logic [N*W-1:0] s_data;
        logic [N-1:0]   s_last;
        logic [N-1:0]   s_ready;
        logic           m_valid;
        logic [W-1:0]   m_data;
        logic           m_ready;
        logic [N-1:0]   grant;
        logic           busy;

        word_t exp_q[N][$];
        word_t cur[N];
        bit [N-1:0] pres;
        bit [N-1:0] hs;
        bit         xfer;
        int         remaining[N];
        int         owner    = -1;
        int         gap_left = 0;
        int         rr       = 0;
        int         n_xfer   = 0;

        uart_tx_arbiter #(
            .NUM_REQ   (N),
            .W_DATA    (W),
            .GAP_CLOCKS(GAP)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .s_valid(s_valid),
            .s_data (s_data),
            .s_last (s_last),
            .s_ready(s_ready),
            .m_valid(m_valid),
            .m_data (m_data),
            .m_ready(m_ready),
            .grant  (grant),
            .busy   (busy)
        );

        // Requesters and a uart_tx stand-in: ready drops for a random while after each word.
        initial begin
            int wait_rdy;
            wait_rdy = 0;
            s_valid  = '0;
            s_data   = '0;
            s_last   = '0;
            m_ready  = 1'b1;
            pres     = '0;
            for (int i = 0; i < N; i++) remaining[i] = 0;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    pres     = '0;
                    wait_rdy = 0;
                    for (int i = 0; i < N; i++) begin
                        exp_q[i].delete();
                        remaining[i] = 0;
                    end
                    s_valid = rst_ones ? '1 : '0;
                    s_data  = '1;
                    s_last  = '1;
                    m_ready = 1'b1;
                end else begin
                    pres = pres & ~hs;
                    if (xfer) wait_rdy = $urandom_range(0, 4);
                    for (int i = 0; i < N; i++) begin
                        if (!pres[i] && (phase == 1 || $urandom_range(0, 3) == 0)) begin
                            if (remaining[i] == 0)
                                remaining[i] = (phase == 1) ? 1 : $urandom_range(1, 4);
                            cur[i].data = W'($urandom);
                            cur[i].last = (remaining[i] == 1);
                            remaining[i]--;
                            exp_q[i].push_back(cur[i]);
                            pres[i] = 1'b1;
                        end
                        s_valid[i]       = pres[i] && (phase == 1 || $urandom_range(0, 7) != 0);
                        s_data[i*W +: W] = cur[i].data;
                        s_last[i]        = cur[i].last;
                    end
                    if (rdy_force_low) begin
                        m_ready = 1'b0;
                    end else if (wait_rdy > 0) begin
                        m_ready = 1'b0;
                        wait_rdy--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            end
        end

        // Reference model: owner / remaining guard clocks / round-robin start, stepped per clock.
        always @(negedge clk) begin
            if (rst) begin
                owner    = -1;
                gap_left = 0;
                rr       = 0;
                hs       = '0;
                xfer     = 1'b0;
                chk("rst_grant", c, 32'(grant), 32'd0);
                chk("rst_busy", c, 32'(busy), 32'd0);
                chk("rst_m_valid", c, 32'(m_valid), 32'd0);
                chk("rst_s_ready", c, 32'(s_ready), 32'd0);
                chk("rst_m_data", c, 32'(m_data), 32'd0);
            end else begin
                hs   = s_valid & s_ready;
                xfer = m_valid & m_ready;
                chk("grant", c, 32'(grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
                chk("busy", c, 32'(busy), 32'(owner >= 0 || gap_left > 0));
                chk("m_valid", c, 32'(m_valid), 32'(owner >= 0 && s_valid[owner]));
                chk("s_ready", c, 32'(s_ready), (owner >= 0 && m_ready) ? (32'd1 << owner) : 32'd0);
                chk("m_data", c, 32'(m_data), (owner >= 0) ? 32'(s_data[owner*W +: W]) : 32'd0);
                if (owner >= 0) begin
                    if (s_valid[owner] && m_ready) begin
                        if (exp_q[owner].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_empty cfg%0d t=%0t: transfer from req%0d with no queued word", c, $time, owner);
                        end else begin
                            word_t w;
                            w = exp_q[owner].pop_front();
                            n_xfer++;
                            chk("sb_data", c, 32'(m_data), 32'(w.data));
                            if (w.last) begin
                                rr       = (owner + 1) % N;
                                owner    = -1;
                                gap_left = GAP;
                            end
                        end
                    end
                end else if (gap_left > 0) begin
                    if (m_ready) gap_left--;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (owner < 0 && s_valid[(rr + k) % N]) owner = (rr + k) % N;
                    end
                end
            end
        end

        // Reset must clear the outputs without waiting for a clock edge.
        always @(posedge rst) begin
            #1;
            chk("async_grant", c, 32'(grant), 32'd0);
            chk("async_busy", c, 32'(busy), 32'd0);
            chk("async_m_valid", c, 32'(m_valid), 32'd0);
            chk("async_s_ready", c, 32'(s_ready), 32'd0);
            chk("async_m_data", c, 32'(m_data), 32'd0);
        end
    end

    task automatic release_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ones = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int t;
        n_checks      = 0;
        n_fail        = 0;
        phase         = 0;
        rst_ones      = 1'b1;
        rdy_force_low = 1'b0;
        rst           = 1'b0;
        #3 rst = 1'b1;
        release_reset();

        phase = 0;
        repeat (1500) @(posedge clk);

        t = 0;
        do begin
            @(negedge clk);
            #2;
            t++;
        end while (g_cfg[0].grant == '0 && t < 200);
        if (g_cfg[0].grant == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL lock_wait cfg0: no grant within %0d clocks", t);
        end
        rst_ones = 1'b1;
        rst      = 1'b1;
        release_reset();

        phase = 1;
        repeat (1500) @(posedge clk);

        phase = 2;
        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(10, 50)) @(posedge clk);
            @(negedge clk);
            rdy_force_low = 1'b1;
            repeat (20) @(negedge clk);
            rdy_force_low = 1'b0;
        end
        repeat (50) @(posedge clk);

        @(negedge clk);
        #2;
        chk("traffic", 0, 32'(g_cfg[0].n_xfer > 200), 32'd1);
        chk("traffic", 1, 32'(g_cfg[1].n_xfer > 200), 32'd1);
        chk("traffic", 2, 32'(g_cfg[2].n_xfer > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
